sid_pdm_out: RTL and testbench

//   Audio output stage downstream of sid_top: consumes the 8-bit audio_out sample and

---
 rtl/sid_pdm_out_if.sv | 28 ++
 rtl/sid_pdm_out.sv | 133 +++++++++++++
 tb/tb_sid_pdm_out.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sid_pdm_out_if.sv
// sid_pdm_out_if: audio sample and mute control in,
// 1-bit PDM stream and ramp status out.
interface sid_pdm_out_if;
  logic [7:0] audio_in;
  logic       enable;
  logic       sample_tick;
  logic       pdm_out;
  logic       muted;
  logic       ramping;

  modport master (
    output audio_in,
    output enable,
    input  sample_tick,
    input  pdm_out,
    input  muted,
    input  ramping
  );

  modport slave (
    input  audio_in,
    input  enable,
    output sample_tick,
    output pdm_out,
    output muted,
    output ramping
  );
endinterface

// File: rtl/sid_pdm_out.sv
// sid_pdm_out: prescaled sample capture, soft mute gain ramp
// and first-order sigma-delta modulator driving one pin.
module sid_pdm_out #(
  parameter int CLK_DIV = 1024
) (
  input  logic         clk,
  input  logic         rst,
  sid_pdm_out_if.slave bus
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    MUTED,
    RAMP_UP,
    ACTIVE,
    RAMP_DOWN
  } state_t;

  logic [DW-1:0] div_cnt;
  logic          wrap;
  logic          tick_q;
  logic [7:0]    sample_reg;
  state_t        state;
  logic [8:0]    gain;
  logic          muted_q;
  logic          ramping_q;
  logic [7:0]    scaled;
  logic [7:0]    scaled_d;
  logic [7:0]    acc;
  logic [8:0]    sum;
  logic          pdm_q;

  assign wrap = (div_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      tick_q  <= 1'b0;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + 1'b1;
      tick_q  <= wrap;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_reg <= '0;
    end else if (wrap) begin
      sample_reg <= bus.audio_in;
    end
  end

  // Reversals hold gain for one tick; the clamps cover a
  // reversal that happens right at 0 or 256.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= MUTED;
      gain      <= '0;
      muted_q   <= 1'b1;
      ramping_q <= 1'b0;
    end else if (wrap) begin
      unique case (state)
        MUTED: begin
          if (bus.enable) begin
            state     <= RAMP_UP;
            muted_q   <= 1'b0;
            ramping_q <= 1'b1;
          end
        end
        RAMP_UP: begin
          if (!bus.enable) begin
            state <= RAMP_DOWN;
          end else if (gain >= 9'd255) begin
            gain      <= 9'd256;
            state     <= ACTIVE;
            ramping_q <= 1'b0;
          end else begin
            gain <= gain + 9'd1;
          end
        end
        ACTIVE: begin
          if (!bus.enable) begin
            state     <= RAMP_DOWN;
            ramping_q <= 1'b1;
          end
        end
        RAMP_DOWN: begin
          if (bus.enable) begin
            state <= RAMP_UP;
          end else if (gain <= 9'd1) begin
            gain      <= '0;
            state     <= MUTED;
            muted_q   <= 1'b1;
            ramping_q <= 1'b0;
          end else begin
            gain <= gain - 9'd1;
          end
        end
      endcase
    end
  end

  // 17-bit product; gain 256 makes this an exact pass-through.
  assign scaled_d = 8'(({9'd0, sample_reg} * {8'd0, gain}) >> 8);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scaled <= '0;
    end else begin
      scaled <= scaled_d;
    end
  end

  assign sum = {1'b0, acc} + {1'b0, scaled};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      pdm_q <= 1'b0;
    end else begin
      acc   <= sum[7:0];
      pdm_q <= sum[8];
    end
  end

  assign bus.sample_tick = tick_q;
  assign bus.pdm_out     = pdm_q;
  assign bus.muted       = muted_q;
  assign bus.ramping     = ramping_q;

endmodule

// File: tb/tb_sid_pdm_out.sv
// tb_sid_pdm_out: random and directed stimulus checked every
// cycle against a tick-level behavioural model of the output stage.
module tb_sid_pdm_out;
  localparam int DIV = 16;

  localparam int M_MUTED = 0;
  localparam int M_UP    = 1;
  localparam int M_FULL  = 2;
  localparam int M_DOWN  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int failures = 0;

  sid_pdm_out_if bus();

  sid_pdm_out #(.CLK_DIV(DIV)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int m_edges = 0;
  int m_sample = 0;
  int m_gain = 0;
  int m_mode = M_MUTED;
  int m_scaled = 0;
  int m_acc = 0;
  int m_pdm = 0;
  int m_tick = 0;

  function automatic void chk(input string name, input int act,
                              input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t",
               name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_edges = 0;
    m_sample = 0;
    m_gain = 0;
    m_mode = M_MUTED;
    m_scaled = 0;
    m_acc = 0;
    m_pdm = 0;
    m_tick = 0;
  endtask

  task automatic model_gain(input bit en);
    case (m_mode)
      M_MUTED: if (en) m_mode = M_UP;
      M_UP: begin
        if (!en) m_mode = M_DOWN;
        else begin
          m_gain = (m_gain + 1 > 256) ? 256 : m_gain + 1;
          if (m_gain == 256) m_mode = M_FULL;
        end
      end
      M_FULL: if (!en) m_mode = M_DOWN;
      default: begin
        if (en) m_mode = M_UP;
        else begin
          m_gain = (m_gain - 1 < 0) ? 0 : m_gain - 1;
          if (m_gain == 0) m_mode = M_MUTED;
        end
      end
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        int s;
        bit t;
        s = m_acc + m_scaled;
        m_pdm = (s >= 256) ? 1 : 0;
        m_acc = s % 256;
        m_scaled = (m_sample * m_gain) / 256;
        t = ((m_edges % DIV) == DIV - 1);
        m_edges++;
        m_tick = t ? 1 : 0;
        if (t) begin
          m_sample = int'(bus.audio_in);
          model_gain(bus.enable);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("pdm_out", int'(bus.pdm_out), m_pdm);
        chk("sample_tick", int'(bus.sample_tick), m_tick);
        chk("muted", int'(bus.muted), (m_mode == M_MUTED) ? 1 : 0);
        chk("ramping", int'(bus.ramping),
            (m_mode == M_UP || m_mode == M_DOWN) ? 1 : 0);
        chk("gain", int'(dut.gain), m_gain);
        chk("scaled", int'(dut.scaled), m_scaled);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    int seen;
    int guard;
    seen = 0;
    guard = 0;
    while (seen < n && guard < (n + 4) * DIV) begin
      @(negedge clk);
      guard++;
      if (bus.sample_tick) seen++;
    end
    chk("tick_wait", seen, n);
  endtask

  task automatic count_ones(input string name, input int want);
    int ones;
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      ones += int'(bus.pdm_out);
    end
    chk(name, ones, want);
  endtask

  initial begin
    int first;
    int cnt;
    int prev;
    int n;
    int seen;
    int ramp_ticks;
    int peak;
    int want;
    int hits;
    int last_scaled;
    bus.audio_in = 8'h00;
    bus.enable = 1'b0;
    #1 rst = 1'b1;

    // prescaler: first tick 16 clocks after release, then every 16
    do_reset();
    first = 0;
    cnt = 0;
    prev = 0;
    for (n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (bus.sample_tick) begin
        if (first == 0) first = n;
        if (prev != 0) chk("tick_spacing", n - prev, DIV);
        prev = n;
        cnt++;
      end
    end
    chk("first_tick", first, 16);
    chk("tick_count", cnt, 12);

    // full ramp up at 128 then density 128/256
    bus.audio_in = 8'd128;
    bus.enable = 1'b1;
    do_reset();
    ramp_ticks = 0;
    seen = 0;
    for (int k = 0; k < 280 * DIV && seen < 270; k++) begin
      @(negedge clk);
      if (bus.sample_tick) begin
        seen++;
        if (bus.ramping) ramp_ticks++;
      end
    end
    chk("ramp_ticks", ramp_ticks, 256);
    chk("active_muted", int'(bus.muted), 0);
    chk("active_ramping", int'(bus.ramping), 0);
    count_ones("ones_0x80", 128);

    bus.audio_in = 8'h40;
    wait_ticks(2);
    count_ones("ones_0x40", 64);
    bus.audio_in = 8'hFF;
    wait_ticks(2);
    count_ones("ones_0xFF", 255);
    bus.audio_in = 8'h00;
    wait_ticks(2);
    count_ones("ones_0x00", 0);

    // async reset mid ramp-down, no clock edge involved
    bus.audio_in = 8'hFF;
    bus.enable = 1'b0;
    wait_ticks(5);
    chk("pre_rst_ramping", int'(bus.ramping), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_pdm", int'(bus.pdm_out), 0);
    chk("rst_muted", int'(bus.muted), 1);
    chk("rst_ramping", int'(bus.ramping), 0);
    chk("rst_tick", int'(bus.sample_tick), 0);
    chk("rst_gain", int'(dut.gain), 0);
    repeat (2) @(negedge clk);
    bus.enable = 1'b1;
    rst = 1'b0;
    wait_ticks(3);
    chk("restart_gain", int'(dut.gain), 2);

    // 101 enabled ticks peak at 100 (first tick only leaves MUTED)
    bus.audio_in = 8'h80;
    bus.enable = 1'b1;
    do_reset();
    wait_ticks(101);
    bus.enable = 1'b0;
    chk("peak_gain", int'(dut.gain), 100);
    seen = 0;
    peak = 0;
    for (int k = 0; k < 130 * DIV; k++) begin
      @(negedge clk);
      if (int'(dut.gain) > peak) peak = int'(dut.gain);
      if (bus.sample_tick) begin
        seen++;
        if (bus.muted) break;
      end
    end
    chk("down_ticks", seen, 101);
    chk("down_peak", peak, 100);

    // scaled tracks gain*128>>8 monotonically
    bus.audio_in = 8'h80;
    bus.enable = 1'b1;
    do_reset();
    want = -1;
    hits = 0;
    last_scaled = 0;
    for (int k = 0; k < 300 * DIV && hits < 3; k++) begin
      @(negedge clk);
      if (want >= 0) begin
        chk("scaled_point", int'(dut.scaled), want);
        want = -1;
        hits++;
      end
      if (int'(dut.scaled) < last_scaled)
        chk("scaled_monotonic", int'(dut.scaled), last_scaled);
      last_scaled = int'(dut.scaled);
      if (bus.sample_tick) begin
        if (m_gain == 0) want = 0;
        else if (m_gain == 128) want = 64;
        else if (m_gain == 256) want = 128;
      end
    end
    chk("scaled_points", hits, 3);

    // random audio, enable toggles and occasional resets
    do_reset();
    for (int k = 0; k < 9000; k++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      if ($urandom_range(0, 39) == 0) bus.audio_in = 8'($urandom);
      if ($urandom_range(0, 499) == 0) bus.enable = ~bus.enable;
      if ($urandom_range(0, 2999) == 0) rst = 1'b1;
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
